data_mem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 13 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/data_mem_responder.sv | 81 ++++++++
 tb/tb_data_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizes for data_mem_responder and its write buffer
package dmem_pkg;
  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_WB_DEPTH = 4;
  localparam int IDX_W = $clog2(DMEM_DEPTH);
  localparam int WB_PTR_W = $clog2(DMEM_WB_DEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, LOAD} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0] data;
    logic [3:0] be;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular store buffer with parallel word-index match (RAW_FORWARD_EN adds youngest-match forwarding)
module wb_fifo import dmem_pkg::*; #(
  parameter int DEPTH = DMEM_WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  input  logic [IDX_W-1:0] q_idx,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic             any_match,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data
);
  wb_entry_t mem [DEPTH];
  logic [WB_PTR_W-1:0] wr_ptr, rd_ptr, off;
  logic [WB_PTR_W:0] count;
  logic [DEPTH-1:0] hit;
  assign full = count == (WB_PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign any_match = |hit;
  // an entry is live when its distance from the read pointer is below the count
  always_comb begin
    hit = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = WB_PTR_W'(i) - rd_ptr;
      hit[i] = ({1'b0, off} < count) && (mem[i].idx == q_idx);
    end
  end
`ifdef RAW_FORWARD_EN
  logic [WB_PTR_W-1:0] p;
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    p = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      p = rd_ptr + WB_PTR_W'(k);
      if (hit[p]) begin
        fwd_hit = &mem[p].be;
        fwd_data = mem[p].data;
      end
    end
  end
`else
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (WB_PTR_W+1)'(push) - (WB_PTR_W+1)'(pop);
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with posted-store buffer; RAW_FORWARD_EN enables full-word store forwarding
module data_mem_responder import dmem_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH_WORDS = DMEM_DEPTH,
  parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] MEM_ADDR,
  input  logic [3:0]       WRITE_MEM_EN,
  input  logic [WIDTH-1:0] WRITE_MEM_DATA,
  output logic [WIDTH-1:0] READ_MEM_DATA,
  output logic             RESP_VALID,
  output logic             WB_EMPTY
);
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0] req_idx, ld_idx, rd_idx, q_idx;
  logic [31:0] fwd_data;
  logic full, any_match, fwd, accept, ld_acc, push, pop, rd_en, use_fwd, unused_addr;
  wb_entry_t head;
  assign unused_addr = ^{MEM_ADDR[WIDTH-1:IDX_W+2], MEM_ADDR[1:0]};
  assign req_idx = MEM_ADDR[IDX_W+1:2];
  assign REQ_READY = RESET && state == IDLE && !full;
  assign accept = REQ_VALID && REQ_READY;
  assign ld_acc = accept && WRITE_MEM_EN == 4'b0000;
  assign push = accept && |WRITE_MEM_EN;
  assign q_idx = state == IDLE ? req_idx : ld_idx;
  assign use_fwd = state == IDLE && fwd;
  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(RESET),
    .push(push),
    .pop(pop),
    .din('{idx: req_idx, data: WRITE_MEM_DATA, be: WRITE_MEM_EN}),
    .q_idx(q_idx),
    .head(head),
    .full(full),
    .empty(WB_EMPTY),
    .any_match(any_match),
    .fwd_hit(fwd),
    .fwd_data(fwd_data)
  );
  // drains only use the array port on cycles with no accepted request, so stores back up into the buffer
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    rd_en = 1'b0;
    rd_idx = req_idx;
    if (state == IDLE) begin
      rd_en = ld_acc && (!any_match || fwd);
      state_nx = ld_acc && any_match && !fwd ? FLUSH : IDLE;
      pop = RESET && !accept && !WB_EMPTY;
    end else if (state == FLUSH) begin
      pop = RESET && any_match;
      rd_en = !any_match;
      rd_idx = ld_idx;
      state_nx = any_match ? FLUSH : LOAD;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      state <= IDLE;
      RESP_VALID <= 1'b0;
      READ_MEM_DATA <= '0;
      ld_idx <= '0;
    end else begin
      state <= state_nx;
      RESP_VALID <= rd_en;
      if (ld_acc) ld_idx <= req_idx;
      if (rd_en) READ_MEM_DATA <= use_fwd ? fwd_data : mem[rd_idx];
    end
  always_ff @(posedge CLK)
    if (pop)
      for (int b = 0; b < 4; b++)
        if (head.be[b]) mem[head.idx][8*b +: 8] <= head.data[8*b +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a response scoreboard checked by an independent monitor
module tb_data_mem_responder;
  logic CLK = 1'b0, RESET = 1'b0, REQ_VALID = 1'b0;
  logic REQ_READY, RESP_VALID, WB_EMPTY;
  logic [31:0] MEM_ADDR = '0, WRITE_MEM_DATA = '0, READ_MEM_DATA;
  logic [3:0] WRITE_MEM_EN = '0;
  int total = 0, bad = 0, cyc = 0, s;
  typedef struct {logic [31:0] data; int at;} exp_t;
  exp_t q[$];
  exp_t me;
`ifdef RAW_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  data_mem_responder dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .MEM_ADDR(MEM_ADDR), .WRITE_MEM_EN(WRITE_MEM_EN), .WRITE_MEM_DATA(WRITE_MEM_DATA),
    .READ_MEM_DATA(READ_MEM_DATA), .RESP_VALID(RESP_VALID), .WB_EMPTY(WB_EMPTY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (RESP_VALID === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: data %h at cycle %0d, no response expected", READ_MEM_DATA, cyc);
      end else begin
        me = q.pop_front();
        if (READ_MEM_DATA !== me.data || cyc != me.at) begin
          bad++;
          $display("FAIL resp: got %h at cycle %0d, expected %h at cycle %0d", READ_MEM_DATA, cyc, me.data, me.at);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic req(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                     input bit exp_resp, input logic [31:0] exp_data, input int lat, output int stall);
    MEM_ADDR = addr;
    WRITE_MEM_EN = be;
    WRITE_MEM_DATA = data;
    REQ_VALID = 1'b1;
    stall = 0;
    while (REQ_READY !== 1'b1 && stall < 40) begin
      @(posedge CLK);
      #1;
      stall++;
    end
    if (stall >= 40) begin
      total++;
      bad++;
      $display("FAIL req_timeout: addr %h never accepted, REQ_READY=%b expected 1", addr, REQ_READY);
      REQ_VALID = 1'b0;
      return;
    end
    if (exp_resp) q.push_back('{exp_data, cyc + lat});
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic st(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    int d;
    req(addr, be, data, 1'b0, '0, 0, d);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
    int d;
    req(addr, 4'b0000, '0, 1'b1, exp_data, lat, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 32'(REQ_READY), 0);
    check("rst_resp", 32'(RESP_VALID), 0);
    check("rst_wb_empty", 32'(WB_EMPTY), 1);
    check("rst_rdata", READ_MEM_DATA, 0);
    RESET = 1'b1;
    idle(2);
    check("ready_after_rst", 32'(REQ_READY), 1);
    check("wb_empty_idle", 32'(WB_EMPTY), 1);

    st(32'h40, 4'hF, 32'h12345678);
    idle(3);
    check("wb_empty_before_load", 32'(WB_EMPTY), 1);
    ld(32'h40, 32'h12345678, 1);

    st(32'h80, 4'hF, 32'hAABBCCDD);
    ld(32'h80, 32'hAABBCCDD, FWD ? 1 : 3);
    check("ready_after_raw_load", 32'(REQ_READY), FWD ? 1 : 0);
    idle(4);

    st(32'h10, 4'hF, 32'h11223344);
    idle(3);
    st(32'h10, 4'b0001, 32'h000000FF);
    idle(3);
    ld(32'h10, 32'h112233FF, 1);
    st(32'h10, 4'b0010, 32'h0000EE00);
    ld(32'h10, 32'h1122EEFF, 3);
    idle(4);

    for (int i = 0; i < 5; i++) begin
      req(32'h100 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b0, '0, 0, s);
      check($sformatf("store%0d_stall", i), 32'(s), i == 4 ? 1 : 0);
    end
    idle(6);
    check("wb_empty_after_fill", 32'(WB_EMPTY), 1);
    for (int i = 0; i < 5; i++) ld(32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1);
    idle(2);

    st(32'h200, 4'hF, 32'hD0D0D0D0);
    st(32'h204, 4'hF, 32'hD1D1D1D1);
    st(32'h208, 4'hF, 32'hD2D2D2D2);
    idle(5);
    st(32'h200, 4'hF, 32'hBAD00000);
    st(32'h204, 4'hF, 32'hBAD00001);
    st(32'h208, 4'b0111, 32'hBAD00002);
    req(32'h208, 4'b0000, '0, 1'b0, '0, 0, s);
    check("ready_in_flush", 32'(REQ_READY), 0);
    check("wb_full_in_flush", 32'(WB_EMPTY), 0);
    RESET = 1'b0;
    idle(2);
    check("abort_wb_empty", 32'(WB_EMPTY), 1);
    check("abort_resp", 32'(RESP_VALID), 0);
    RESET = 1'b1;
    idle(1);
    ld(32'h200, 32'hD0D0D0D0, 1);
    ld(32'h204, 32'hD1D1D1D1, 1);
    ld(32'h208, 32'hD2D2D2D2, 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    idle(2);
    check("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
